// File: rtl/eth_tx_pkt_buf.sv
// Store-and-forward payload buffer for eth_tx: collects one payload, computes its
// length and one's-complement sum, then requests eth_tx and streams it back-to-back.
module eth_tx_pkt_buf #(
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int LEN_W       = $clog2(KEEP_W + 1),
  parameter int PKT_LEN_W   = 16,
  parameter int DEPTH       = 64,
  parameter int BLOCK_N     = 8,
  parameter int BLOCK_LEN_W = $clog2(BLOCK_N + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic [LEN_W-1:0]       wr_len_i,
  input  logic                   wr_last_i,
  input  logic                   wr_cancel_i,
  output logic                   drop_o,
  output logic                   app_early_v_o,
  input  logic                   app_ready_v_i,
  output logic                   app_cancel_o,
  output logic [DATA_W-1:0]      app_data_o,
  output logic [LEN_W-1:0]       app_len_o,
  output logic [PKT_LEN_W-1:0]   app_pkt_len_o,
  output logic [15:0]            app_cs_o,
  output logic                   app_last_o,
  output logic                   app_last_block_next_o,
  output logic [BLOCK_LEN_W-1:0] app_last_block_next_len_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = DATA_W / 16;
  localparam logic [AW:0]          DEPTH_P = (AW + 1)'(DEPTH);
  localparam logic [PKT_LEN_W-1:0] KEEP_P  = PKT_LEN_W'(KEEP_W);
  localparam logic [PKT_LEN_W-1:0] BLOCK_P = PKT_LEN_W'(BLOCK_N);
  localparam logic [LEN_W-1:0]     KEEP_L  = LEN_W'(KEEP_W);

  typedef enum logic [1:0] {FILL, DISCARD, REQ, SEND} state_t;

  state_t                 state_q, state_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PKT_LEN_W-1:0]   cnt_q, cnt_d;
  logic [PKT_LEN_W-1:0]   x_q, x_d;
  logic [15:0]            sum_q, sum_d;
  logic                   drop_q, drop_d;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DATA_W-1:0]      rd_data_q;
  logic [AW-1:0]          rd_addr;
  logic                   mem_we;

  // Bytes past wr_len_i contribute zero, which also pads an odd tail byte.
  logic [15:0] word [NW];
  genvar gi;
  for (gi = 0; gi < NW; gi++) begin : g_word
    localparam logic [LEN_W:0] HI_POS = (LEN_W + 1)'(2 * gi);
    logic hi_v, lo_v;
    assign hi_v = {1'b0, wr_len_i} > HI_POS;
    assign lo_v = {1'b0, wr_len_i} > (HI_POS + 1'b1);
    assign word[gi] = {hi_v ? wr_data_i[16*gi +: 8] : 8'h00,
                       lo_v ? wr_data_i[16*gi+8 +: 8] : 8'h00};
  end

  logic [31:0] acc;
  logic [16:0] fold1;
  logic [15:0] sum_new;
  always_comb begin
    acc = {16'h0, sum_q};
    for (int i = 0; i < NW; i++) begin
      acc = acc + {16'h0, word[i]};
    end
    fold1   = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    sum_new = fold1[15:0] + {15'h0, fold1[16]};
  end

  logic [PKT_LEN_W:0]   cnt_sum;
  logic                 overflow;
  assign cnt_sum  = {1'b0, cnt_q} + {{(PKT_LEN_W + 1 - LEN_W){1'b0}}, wr_len_i};
  assign overflow = (wr_ptr_q == DEPTH_P) || cnt_sum[PKT_LEN_W];

  logic [PKT_LEN_W-1:0] rem, lb_x;
  logic [PKT_LEN_W:0]   x_end;
  logic                 send_last, lb_hit;
  assign rem       = cnt_q - x_q;
  assign send_last = rem <= KEEP_P;
  assign lb_x      = ((cnt_q - 1'b1) / BLOCK_P) * BLOCK_P;
  assign x_end     = {1'b0, x_q} + {1'b0, KEEP_P};
  assign lb_hit    = (x_q <= lb_x) && ({1'b0, lb_x} < x_end);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    sum_d    = sum_q;
    drop_d   = 1'b0;
    mem_we   = 1'b0;
    rd_addr  = '0;
    case (state_q)
      FILL: begin
        if (wr_cancel_i) begin
          wr_ptr_d = '0;
          cnt_d    = '0;
          sum_d    = '0;
        end else if (wr_valid_i) begin
          if (overflow) begin
            drop_d   = 1'b1;
            wr_ptr_d = '0;
            cnt_d    = '0;
            sum_d    = '0;
            if (!wr_last_i) state_d = DISCARD;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_sum[PKT_LEN_W-1:0];
            sum_d    = sum_new;
            if (wr_last_i) begin
              if (cnt_sum[PKT_LEN_W-1:0] != '0) begin
                state_d = REQ;
              end else begin
                wr_ptr_d = '0;
                cnt_d    = '0;
                sum_d    = '0;
              end
            end
          end
        end
      end
      DISCARD: begin
        if (wr_cancel_i || (wr_valid_i && wr_last_i)) state_d = FILL;
      end
      REQ: begin
        // Prefetch beat 0 so the first SEND cycle already has data.
        if (app_ready_v_i) begin
          state_d  = SEND;
          rd_ptr_d = '0;
          x_d      = '0;
        end
      end
      SEND: begin
        rd_addr  = rd_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        x_d      = x_q + KEEP_P;
        if (send_last) begin
          state_d  = FILL;
          rd_ptr_d = '0;
          x_d      = '0;
          wr_ptr_d = '0;
          cnt_d    = '0;
          sum_d    = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      sum_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      sum_q    <= sum_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    rd_data_q <= mem[rd_addr];
  end

  logic in_send, has_pkt;
  assign in_send = (state_q == SEND);
  assign has_pkt = (state_q == REQ) || in_send;

  assign wr_ready_o                = (state_q == FILL) || (state_q == DISCARD);
  assign drop_o                    = drop_q;
  assign app_early_v_o             = (state_q == REQ);
  assign app_cancel_o              = 1'b0;
  assign app_data_o                = in_send ? rd_data_q : '0;
  assign app_len_o                 = in_send ? (send_last ? rem[LEN_W-1:0] : KEEP_L) : '0;
  assign app_pkt_len_o             = has_pkt ? cnt_q : '0;
  assign app_cs_o                  = has_pkt ? sum_q : '0;
  assign app_last_o                = in_send && send_last;
  assign app_last_block_next_o     = in_send && lb_hit;
  assign app_last_block_next_len_o = (in_send && lb_hit) ? BLOCK_LEN_W'(cnt_q - lb_x) : '0;

endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// Randomized and directed bench for eth_tx_pkt_buf; expected beats, length and
// checksum come from a byte-queue reference model.
module tb_eth_tx_pkt_buf;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 2;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [DATA_W-1:0] wr_data_i;
  logic [LEN_W-1:0]  wr_len_i;
  logic              wr_last_i;
  logic              wr_cancel_i;
  logic              drop_o;
  logic              app_early_v_o;
  logic              app_ready_v_i;
  logic              app_cancel_o;
  logic [DATA_W-1:0] app_data_o;
  logic [LEN_W-1:0]  app_len_o;
  logic [15:0]       app_pkt_len_o;
  logic [15:0]       app_cs_o;
  logic              app_last_o;
  logic              app_last_block_next_o;
  logic [3:0]        app_last_block_next_len_o;

  eth_tx_pkt_buf dut (
    .clk                       (clk),
    .reset                     (reset),
    .wr_valid_i                (wr_valid_i),
    .wr_ready_o                (wr_ready_o),
    .wr_data_i                 (wr_data_i),
    .wr_len_i                  (wr_len_i),
    .wr_last_i                 (wr_last_i),
    .wr_cancel_i               (wr_cancel_i),
    .drop_o                    (drop_o),
    .app_early_v_o             (app_early_v_o),
    .app_ready_v_i             (app_ready_v_i),
    .app_cancel_o              (app_cancel_o),
    .app_data_o                (app_data_o),
    .app_len_o                 (app_len_o),
    .app_pkt_len_o             (app_pkt_len_o),
    .app_cs_o                  (app_cs_o),
    .app_last_o                (app_last_o),
    .app_last_block_next_o     (app_last_block_next_o),
    .app_last_block_next_len_o (app_last_block_next_len_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] pkt_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One's-complement sum of big-endian byte pairs, odd tail padded with zero.
  function automatic logic [15:0] model_cs();
    int unsigned s = 0;
    for (int k = 0; k < pkt_q.size(); k += 2) begin
      s += {pkt_q[k], (k + 1 < pkt_q.size()) ? pkt_q[k+1] : 8'h00};
    end
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  task automatic idle_inputs();
    wr_valid_i  = 1'b0;
    wr_data_i   = '0;
    wr_len_i    = '0;
    wr_last_i   = 1'b0;
    wr_cancel_i = 1'b0;
  endtask

  task automatic drive_beat(input logic [15:0] d, input logic [1:0] len, input logic last);
    @(negedge clk);
    chk("wr_ready", wr_ready_o, 1);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    wr_len_i   = len;
    wr_last_i  = last;
  endtask

  task automatic write_pkt();
    int n = pkt_q.size();
    int nb = (n + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      logic [7:0] hi_b;
      hi_b = (2 * b + 1 < n) ? pkt_q[2*b+1] : 8'($urandom);
      drive_beat({hi_b, pkt_q[2*b]}, (2 * b + 1 < n) ? 2'd2 : 2'd1, b == nb - 1);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Called at the negedge right after the final write beat was accepted.
  task automatic expect_send(input int hold, input int abort_at);
    int L = pkt_q.size();
    int nb = (L + 1) / 2;
    int lbx = ((L - 1) / 8) * 8;
    logic [15:0] cs = model_cs();
    chk("req_early_v", app_early_v_o, 1);
    chk("req_pkt_len", app_pkt_len_o, L);
    chk("req_cs", app_cs_o, cs);
    chk("req_wr_ready", wr_ready_o, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_early_v", app_early_v_o, 1);
      chk("hold_pkt_len", app_pkt_len_o, L);
      chk("hold_cs", app_cs_o, cs);
      chk("hold_no_beat", {app_len_o, app_last_o}, 0);
    end
    app_ready_v_i = 1'b1;
    @(negedge clk);
    app_ready_v_i = 1'b0;
    for (int j = 0; j < nb; j++) begin
      int x = 2 * j;
      int len = (L - x >= 2) ? 2 : L - x;
      if (j == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_app_outs", {app_early_v_o, app_len_o, app_last_o, app_last_block_next_o,
                             app_last_block_next_len_o, drop_o}, 0);
        chk("rst_app_data", app_data_o, 0);
        chk("rst_app_len_cs", {app_pkt_len_o, app_cs_o}, 0);
        chk("rst_wr_ready", wr_ready_o, 1);
        $display("[TB] pkt L=%0d aborted by reset at beat %0d", L, j);
        return;
      end
      chk("send_early_v", app_early_v_o, 0);
      chk("send_len", app_len_o, len);
      chk("send_byte0", app_data_o[7:0], pkt_q[x]);
      if (len == 2) chk("send_byte1", app_data_o[15:8], pkt_q[x+1]);
      chk("send_last", app_last_o, j == nb - 1);
      chk("send_lb", app_last_block_next_o, x == lbx);
      chk("send_lb_len", app_last_block_next_len_o, (x == lbx) ? L - lbx : 0);
      chk("send_pkt_len", app_pkt_len_o, L);
      chk("send_cs", app_cs_o, cs);
      @(negedge clk);
    end
    chk("post_wr_ready", wr_ready_o, 1);
    chk("post_idle", {app_early_v_o, app_len_o, app_last_o}, 0);
    $display("[TB] pkt L=%0d cs=%04h sent in %0d beats", L, cs, nb);
  endtask

  initial begin
    reset = 1'b1;
    app_ready_v_i = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_wr_ready", wr_ready_o, 1);
    chk("reset_outs", {drop_o, app_early_v_o, app_cancel_o, app_len_o, app_last_o,
                       app_last_block_next_o, app_last_block_next_len_o}, 0);
    chk("reset_len_cs", {app_pkt_len_o, app_cs_o}, 0);
    chk("reset_data", app_data_o, 0);

    pkt_q = {};
    for (int i = 1; i <= 10; i++) pkt_q.push_back(8'(i));
    write_pkt();
    expect_send(0, -1);

    pkt_q = {8'h01, 8'h02, 8'h03};
    write_pkt();
    chk("cs_3byte", app_cs_o, 16'h0402);
    expect_send(1, -1);

    pkt_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 12; i++) pkt_q.push_back(8'h00);
    write_pkt();
    chk("cs_carry", app_cs_o, 16'hFFFF);
    expect_send(2, -1);

    // Overflow on beat DEPTH+1, then two more beats discarded through wr_last_i.
    for (int b = 1; b <= DEPTH + 3; b++) begin
      drive_beat(16'($urandom), 2'd2, b == DEPTH + 3);
      chk("ovf_drop", drop_o, b == DEPTH + 2);
      chk("ovf_no_req", app_early_v_o, 0);
    end
    @(negedge clk);
    idle_inputs();
    chk("ovf_drop_end", drop_o, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ovf_no_req_after", app_early_v_o, 0);
    end
    $display("[TB] overflow packet of %0d beats dropped", DEPTH + 3);
    pkt_q = {};
    for (int i = 0; i < 4; i++) pkt_q.push_back(8'($urandom));
    write_pkt();
    expect_send(0, -1);

    // Cancel after 3 beats; cancel wins over a simultaneous last beat.
    for (int b = 0; b < 3; b++) drive_beat(16'hA5A5, 2'd2, 1'b0);
    drive_beat(16'h5A5A, 2'd2, 1'b1);
    wr_cancel_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("cancel_no_req", app_early_v_o, 0);
    chk("cancel_no_drop", drop_o, 0);
    chk("cancel_wr_ready", wr_ready_o, 1);
    $display("[TB] packet cancelled after 3 beats");
    pkt_q = {};
    for (int i = 0; i < 7; i++) pkt_q.push_back(8'($urandom));
    write_pkt();
    expect_send(0, -1);

    for (int p = 0; p < 20; p++) begin
      int n = $urandom_range(1, 2 * DEPTH);
      pkt_q = {};
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
      write_pkt();
      expect_send($urandom_range(0, 4), -1);
    end

    pkt_q = {};
    for (int i = 0; i < 10; i++) pkt_q.push_back(8'($urandom));
    write_pkt();
    expect_send(0, 2);

    pkt_q = {};
    for (int i = 0; i < 9; i++) pkt_q.push_back(8'($urandom));
    write_pkt();
    expect_send(20, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
